// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the weighted round-robin bus arbiter.
// Default sizing constants, the FSM state encoding and the zero-weight mapping.
package bus_arb_pkg;

  localparam int DEF_DRVS   = 8;
  localparam int DEF_WGHT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // A zero weight would starve its driver, so it is promoted to one packet.
  function automatic logic [31:0] eff_wght(input logic [31:0] w);
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set req bit at or after base, wrapping modulo DRVS.
// The request vector is doubled and shifted so the search always starts at bit 0.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter  int DRVS = DEF_DRVS,
  localparam int IW   = $clog2(DRVS)
) (
  input  logic [DRVS-1:0] req,
  input  logic [IW-1:0]   base,
  output logic            found,
  output logic [IW-1:0]   idx
);

  logic [DRVS-1:0] rot;
  logic [IW-1:0]   off;
  logic [IW:0]     sum;

  assign rot   = DRVS'({req, req} >> base);
  assign found = |req;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no latch is inferred and later writes take priority.
  always_comb begin
    off = '0;
    for (int i = DRVS - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
  end

  always_comb begin
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= (IW+1)'(DRVS)) sum = sum - (IW+1)'(DRVS);
    idx = sum[IW-1:0];
  end

endmodule

// File: rtl/bus_wrr_arbiter.sv
// Weighted round-robin bus owner selection: one driver holds the bus for up
// to its weight in packets, then the search resumes just past it.
module bus_wrr_arbiter
  import bus_arb_pkg::*;
#(
  parameter  int DRVS   = DEF_DRVS,
  parameter  int WGHT_W = DEF_WGHT_W,
  localparam int IW     = $clog2(DRVS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DRVS-1:0]   pndng,
  input  logic              cfg_wr,
  input  logic [IW-1:0]     cfg_idx,
  input  logic [WGHT_W-1:0] cfg_wght,
  input  logic              xfer_done,
  output logic [DRVS-1:0]   gnt,
  output logic [IW-1:0]     gnt_id,
  output logic              gnt_vld,
  output logic              err
);

  arb_state_e        state_q;
  logic [DRVS-1:0]   gnt_q;
  logic [IW-1:0]     owner_q;
  logic              gnt_vld_q;
  logic              err_q;
  logic [IW-1:0]     rr_ptr_q;
  logic [WGHT_W-1:0] credit_q;
  logic [WGHT_W-1:0] wght_q [DRVS];

  logic          pick_found;
  logic [IW-1:0] pick_idx;

  rr_pick #(.DRVS(DRVS)) u_pick (
    .req   (pndng),
    .base  (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // NOTE: the weight table is reset like any other register, because every
  // driver must start with a well-defined weight of one.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DRVS; i++) wght_q[i] <= WGHT_W'(1);
    end else if (cfg_wr && (int'(cfg_idx) < DRVS)) begin
      wght_q[cfg_idx] <= cfg_wght;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values; a same-cycle weight write therefore loads the old weight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      gnt_vld_q <= 1'b0;
      err_q     <= 1'b0;
      rr_ptr_q  <= '0;
      credit_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer_done) err_q <= 1'b1;
          if (pick_found) begin
            state_q   <= GRANT;
            owner_q   <= pick_idx;
            gnt_q     <= DRVS'(1) << pick_idx;
            gnt_vld_q <= 1'b1;
            credit_q  <= WGHT_W'(eff_wght(32'(wght_q[pick_idx])));
          end
        end
        GRANT: begin
          // Hold the bus until a completed packet exhausts credit or empties the FIFO.
          if (xfer_done) begin
            credit_q <= credit_q - WGHT_W'(1);
            if ((credit_q == WGHT_W'(1)) || !pndng[owner_q]) begin
              state_q   <= IDLE;
              gnt_q     <= '0;
              gnt_vld_q <= 1'b0;
              rr_ptr_q  <= (owner_q == IW'(DRVS - 1)) ? '0 : owner_q + IW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = owner_q;
  assign gnt_vld = gnt_vld_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bus_wrr_arbiter.sv
// Directed and randomized checks of bus_wrr_arbiter against a cycle-level
// behavioural model built from integer owner/credit/pointer bookkeeping.
module tb_bus_wrr_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pndng = '0;
  logic       cfg_wr = 1'b0;
  logic [2:0] cfg_idx = '0;
  logic [3:0] cfg_wght = '0;
  logic       xfer_done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_vld;
  logic       err;

  bus_wrr_arbiter #(.DRVS(8), .WGHT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .pndng     (pndng),
    .cfg_wr    (cfg_wr),
    .cfg_idx   (cfg_idx),
    .cfg_wght  (cfg_wght),
    .xfer_done (xfer_done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_vld   (gnt_vld),
    .err       (err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  bit m_own;
  int m_owner, m_credit, m_ptr;
  bit m_err;
  int m_wt [8];

  bit rec, prev_vld;
  int cyc_no;
  int gseq [$];
  int gcyc [$];
  int xo [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [7:0] p, input logic x, input logic r,
                      input logic w, input logic [2:0] ix, input logic [3:0] wv);
    bit hit;
    pndng = p; xfer_done = x; reset = r; cfg_wr = w; cfg_idx = ix; cfg_wght = wv;
    @(posedge clk);
    cyc_no++;
    if (r) begin
      m_own = 0; m_ptr = 0; m_err = 0; m_credit = 0;
      for (int i = 0; i < 8; i++) m_wt[i] = 1;
    end else begin
      if (!m_own) begin
        if (x) m_err = 1;
        hit = 0;
        for (int k = 0; k < 8; k++) begin
          if (!hit && p[(m_ptr + k) % 8]) begin
            hit = 1;
            m_owner = (m_ptr + k) % 8;
          end
        end
        if (hit) begin
          m_own = 1;
          m_credit = (m_wt[m_owner] == 0) ? 1 : m_wt[m_owner];
        end
      end else if (x) begin
        m_credit--;
        if (m_credit == 0 || !p[m_owner]) begin
          m_own = 0;
          m_ptr = (m_owner + 1) % 8;
        end
      end
      if (w) m_wt[ix] = int'(wv);
    end
    #1;
    check("gnt_vld", 32'(gnt_vld), 32'(m_own));
    check("gnt", 32'(gnt), m_own ? (32'd1 << m_owner) : 32'd0);
    if (m_own) check("gnt_id", 32'(gnt_id), 32'(m_owner));
    if (r) check("rst_gnt_id", 32'(gnt_id), 32'd0);
    check("err", 32'(err), 32'(m_err));
    if (rec && gnt_vld && !prev_vld) begin
      gseq.push_back(int'(gnt_id));
      gcyc.push_back(cyc_no);
    end
    prev_vld = gnt_vld;
  endtask

  task automatic cyc(input logic [7:0] p, input logic x);
    step(p, x, 1'b0, 1'b0, 3'd0, 4'd0);
  endtask

  task automatic cfgw(input logic [2:0] ix, input logic [3:0] wv);
    step(8'h00, 1'b0, 1'b0, 1'b1, ix, wv);
  endtask

  task automatic rst();
    step(8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0);
  endtask

  initial begin
    // Reset, then reset mid-grant with a coincident xfer_done.
    rst();
    cyc(8'hFF, 1'b0);
    check("pre_rst_vld", 32'(gnt_vld), 32'd1);
    step(8'hFF, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0);
    check("mid_rst_vld", 32'(gnt_vld), 32'd0);
    check("mid_rst_gnt", 32'(gnt), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    cyc(8'h80, 1'b0);
    check("rst_then_d7", 32'(gnt_id), 32'd7);

    // Fairness: all weights 1, every driver pending.
    rst();
    gseq.delete(); gcyc.delete(); rec = 1;
    for (int c = 0; c < 40 && gseq.size() < 9; c++) cyc(8'hFF, m_own);
    rec = 0;
    check("fair_cnt", 32'(gseq.size()), 32'd9);
    foreach (gseq[i]) check("fair_order", 32'(gseq[i]), 32'(i % 8));
    for (int i = 1; i < gcyc.size(); i++) check("fair_bubble", 32'(gcyc[i] - gcyc[i-1]), 32'd2);

    // Weights: driver 2 weight 3, driver 5 weight 0 (treated as 1).
    rst();
    cfgw(3'd2, 4'd3);
    cfgw(3'd5, 4'd0);
    xo.delete();
    for (int c = 0; c < 40 && xo.size() < 5; c++) begin
      if (m_own) xo.push_back(int'(gnt_id));
      cyc(8'b0010_0100, m_own);
    end
    check("wght_cnt", 32'(xo.size()), 32'd5);
    foreach (xo[i]) check("wght_owner", 32'(xo[i]), (i == 3) ? 32'd5 : 32'd2);

    // Early release when the owner's FIFO empties with the 2nd packet.
    rst();
    cfgw(3'd1, 4'd4);
    cyc(8'h02, 1'b0);
    check("early_gnt", 32'(gnt_id), 32'd1);
    cyc(8'h02, 1'b1);
    check("early_hold", 32'(gnt_vld), 32'd1);
    cyc(8'h02, 1'b0);
    cyc(8'h00, 1'b1);
    check("early_rel", 32'(gnt_vld), 32'd0);
    cyc(8'hFF, 1'b0);
    check("early_ptr2", 32'(gnt_id), 32'd2);

    // Pointer wrap from 6 to driver 0, then sticky err.
    rst();
    cyc(8'h20, 1'b0);
    cyc(8'h20, 1'b1);
    cyc(8'h03, 1'b0);
    check("wrap_d0", 32'(gnt_id), 32'd0);
    cyc(8'h03, 1'b1);
    cyc(8'h00, 1'b1);
    check("err_set", 32'(err), 32'd1);
    for (int i = 0; i < 3; i++) cyc(8'h00, 1'b0);
    check("err_sticky", 32'(err), 32'd1);
    rst();
    check("err_clr", 32'(err), 32'd0);

    // Randomized traffic with configuration writes and occasional resets.
    for (int c = 0; c < 600; c++) begin
      step(8'($urandom), ($urandom_range(2) == 0), ($urandom_range(96) == 0),
           ($urandom_range(7) == 0), 3'($urandom), 4'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
